// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module  : dmem_responder_pkg
// Brief   : Shared types and constants for the data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int BYTE_LANES  = 4;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

    // An address is in range when every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module  : dmem_responder_if
// Brief   : Request/response bus between the MEM stage and the data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        req_i;
    logic        wr_i;
    logic [3:0]  sel_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, wr_i, sel_i, addr_i, wdata_i,
        input  stall_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, wr_i, sel_i, addr_i, wdata_i,
        output stall_o, ack_o, rdata_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module  : dmem_array
// Brief   : Single-port word RAM with per-byte write enables and a held read register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    input  wire logic [BYTE_LANES-1:0] i_we,
    input  wire logic                  i_re,
    input  wire logic                  i_clr,
    input  wire logic [ADDR_WIDTH-1:0] i_idx,
    input  wire logic [31:0]           i_wdata,
    output logic      [31:0]           o_rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int n = 0; n < BYTE_LANES; n++) begin
            if (i_we[n]) begin
                r_mem[i_idx][8*n +: 8] <= i_wdata[8*n +: 8];
            end
        end
    end

    // The read register only moves on a response; it holds across writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 32'd0;
        end else if (i_clr) begin
            r_rdata <= 32'd0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Data-memory slave with programmable wait states and stall/ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    dmem_responder_if.slave  bus
);
    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_wr;
    logic [BYTE_LANES-1:0]   r_sel;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic                    r_ack;
    logic                    r_err;

    logic                    w_idle;
    logic                    w_commit;
    logic                    w_wr;
    logic [BYTE_LANES-1:0]   w_sel;
    logic [31:0]             w_addr;
    logic [31:0]             w_wdata;
    logic                    w_inr;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [BYTE_LANES-1:0]   w_we;
    logic                    w_re;
    logic                    w_clr;

    assign w_idle = (r_state == ST_IDLE);

    // With zero latency the commit edge is the accept edge, so live inputs are used.
    assign w_commit = ((r_state == ST_WAIT) && (r_cnt == '0)) ||
                      (w_idle && bus.req_i && (LATENCY == 0));
    assign w_wr     = w_idle ? bus.wr_i    : r_wr;
    assign w_sel    = w_idle ? bus.sel_i   : r_sel;
    assign w_addr   = w_idle ? bus.addr_i  : r_addr;
    assign w_wdata  = w_idle ? bus.wdata_i : r_wdata;
    assign w_inr    = addr_in_range(w_addr, ADDR_WIDTH);
    assign w_idx    = w_addr[ADDR_WIDTH+1:2];
    assign w_we     = (w_commit && w_wr && w_inr) ? w_sel : '0;
    assign w_re     = w_commit && !w_wr && w_inr;
    assign w_clr    = w_commit && !w_inr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_sel   <= '0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_commit;
            r_err <= w_commit && !w_inr;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        r_wr    <= bus.wr_i;
                        r_sel   <= bus.sel_i;
                        r_addr  <= bus.addr_i;
                        r_wdata <= bus.wdata_i;
                        if (LATENCY == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_cnt   <= CNT_W'(LATENCY - 1);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .resetn  (resetn),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_clr   (w_clr),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (bus.rdata_o)
    );

    // Held low during reset so a pending request does not look like a stall.
    assign bus.stall_o = resetn && ((w_idle && bus.req_i) || (r_state == ST_WAIT));
    assign bus.ack_o   = r_ack;
    assign bus.err_o   = r_err;
endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Self-checking bench for dmem_responder at LATENCY 2, 0 and 5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;
    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    int          k_sel;
    logic        req, wr;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic        o_stall, o_ack, o_err;
    logic [31:0] o_rdata;

    int          total = 0;
    int          bad   = 0;
    int          lat [3] = '{2, 0, 5};
    logic [31:0] mem_m   [3][1024];
    logic [31:0] last_rd [3];
    logic [31:0] rd_v;
    logic        er_v;

    always #5 clk = ~clk;

    dmem_responder_if u_if0 ();
    dmem_responder_if u_if1 ();
    dmem_responder_if u_if2 ();

    assign u_if0.req_i = req && (k_sel == 0);
    assign u_if1.req_i = req && (k_sel == 1);
    assign u_if2.req_i = req && (k_sel == 2);
    assign {u_if0.wr_i, u_if0.sel_i, u_if0.addr_i, u_if0.wdata_i} = {wr, sel, addr, wdata};
    assign {u_if1.wr_i, u_if1.sel_i, u_if1.addr_i, u_if1.wdata_i} = {wr, sel, addr, wdata};
    assign {u_if2.wr_i, u_if2.sel_i, u_if2.addr_i, u_if2.wdata_i} = {wr, sel, addr, wdata};

    always_comb begin
        o_stall = u_if0.stall_o; o_ack = u_if0.ack_o; o_err = u_if0.err_o; o_rdata = u_if0.rdata_o;
        case (k_sel)
            1: begin o_stall = u_if1.stall_o; o_ack = u_if1.ack_o; o_err = u_if1.err_o; o_rdata = u_if1.rdata_o; end
            2: begin o_stall = u_if2.stall_o; o_ack = u_if2.ack_o; o_err = u_if2.err_o; o_rdata = u_if2.rdata_o; end
            default: ;
        endcase
    end

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut0 (.clk(clk), .resetn(rst_n[0]), .bus(u_if0));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut1 (.clk(clk), .resetn(rst_n[1]), .bus(u_if1));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(5)) u_dut2 (.clk(clk), .resetn(rst_n[2]), .bus(u_if2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // One full transaction: drive, wait for ack, then compare against the model.
    task automatic do_txn(input int k, input bit w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er);
        int          cyc;
        int          stl;
        bit          got;
        bit          inr;
        int          idx;
        logic [31:0] exp_rd;
        inr = (a[31:12] == 20'd0);
        idx = int'(a[11:2]);
        @(posedge clk); #1;
        k_sel = k; req = 1'b1; wr = w; sel = s; addr = a; wdata = d;
        cyc = 0; stl = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (o_ack) got = 1;
            else begin
                stl += int'(o_stall);
                cyc++;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        check("latency", cyc, lat[k] + 1);
        check("stall_cycles", stl, lat[k] + 1);
        check("resp_stall", 32'(o_stall), 32'd0);
        rd = o_rdata;
        er = o_err;
        if (!inr)      exp_rd = 32'd0;
        else if (!w)   exp_rd = mem_m[k][idx];
        else           exp_rd = last_rd[k];
        if (inr && w) mem_m[k][idx] = (mem_m[k][idx] & ~lane_mask(s)) | (d & lane_mask(s));
        last_rd[k] = exp_rd;
        check("rdata", rd, exp_rd);
        check("err", 32'(er), 32'(!inr));
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("ack_drop", 32'(o_ack), 32'd0);
        check("err_drop", 32'(o_err), 32'd0);
    endtask

    initial begin
        int          cyc;
        int          acks;
        logic [31:0] a;
        logic [31:0] exp_v;

        rst_n = 3'b000;
        k_sel = 0; req = 1'b1; wr = 1'b1; sel = 4'hF; addr = 32'h40; wdata = 32'h0BADCAFE;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;

        // Reset held with a request pending.
        repeat (2) begin
            @(negedge clk);
            check("rst_ack", 32'(o_ack), 32'd0);
            check("rst_stall", 32'(o_stall), 32'd0);
        end
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 3'b111;
        cyc = 0;
        while (!o_ack && cyc < 40) begin
            @(negedge clk);
            if (!o_ack) cyc++;
        end
        check("rst_release_latency", cyc, 3);
        check("rst_release_rdata", o_rdata, 32'd0);
        mem_m[0][16] = 32'h0BADCAFE;
        @(posedge clk); #1;
        req = 1'b0;

        // Full word, byte merge, empty select, out-of-range.
        do_txn(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, rd_v, er_v);
        do_txn(0, 0, 4'h0, 32'h10, 32'h0, rd_v, er_v);
        check("full_word", rd_v, 32'hDEADBEEF);
        check("full_word_err", 32'(er_v), 32'd0);
        do_txn(0, 1, 4'b0010, 32'h10, 32'h55555555, rd_v, er_v);
        do_txn(0, 1, 4'b1000, 32'h10, 32'hAAAAAAAA, rd_v, er_v);
        do_txn(0, 0, 4'h0, 32'h10, 32'h0, rd_v, er_v);
        check("byte_merge", rd_v, 32'hAAAD55EF);
        do_txn(0, 1, 4'b0000, 32'h10, 32'h12345678, rd_v, er_v);
        do_txn(0, 0, 4'h0, 32'h10, 32'h0, rd_v, er_v);
        check("sel_zero", rd_v, 32'hAAAD55EF);
        do_txn(0, 1, 4'hF, 32'h0, 32'h11112222, rd_v, er_v);
        do_txn(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd_v, er_v);
        check("oor_wr_err", 32'(er_v), 32'd1);
        do_txn(0, 0, 4'h0, 32'h1000, 32'h0, rd_v, er_v);
        check("oor_rd_data", rd_v, 32'd0);
        check("oor_rd_err", 32'(er_v), 32'd1);
        do_txn(0, 0, 4'h0, 32'h0, 32'h0, rd_v, er_v);
        check("oor_mem_kept", rd_v, 32'h11112222);
        check("inr_err_clear", 32'(er_v), 32'd0);

        // Zero latency: request held high across four reads.
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 4'hF, 32'h100 + 32'(4 * i), $urandom, rd_v, er_v);
        @(posedge clk); #1;
        k_sel = 1; req = 1'b1; wr = 1'b0; addr = 32'h100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("l0_ack", 32'(o_ack), 32'(c % 2));
            check("l0_stall", 32'(o_stall), 32'(c % 2 == 0));
            if (o_ack) begin
                exp_v = mem_m[1][int'(addr[11:2])];
                check("l0_rdata", o_rdata, exp_v);
                last_rd[1] = exp_v;
                addr = addr + 32'd4;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;

        // Reset while waiting drops the transaction.
        do_txn(2, 1, 4'hF, 32'h20, 32'hCAFEF00D, rd_v, er_v);
        @(posedge clk); #1;
        k_sel = 2; req = 1'b1; wr = 1'b1; sel = 4'hF; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        req = 1'b0;
        @(negedge clk);
        check("wait_rst_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        last_rd[2] = 32'd0;
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            acks += int'(o_ack);
        end
        check("wait_rst_no_ack", acks, 0);
        do_txn(2, 0, 4'h0, 32'h20, 32'h0, rd_v, er_v);
        check("wait_rst_old_data", rd_v, 32'hCAFEF00D);

        // Randomised traffic on each latency against the model.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++)
                do_txn(k, 1, 4'hF, 32'(4 * i), $urandom, rd_v, er_v);
            for (int t = 0; t < 20; t++) begin
                if ($urandom_range(0, 5) == 0)
                    a = (32'h1 << $urandom_range(12, 31)) | ($urandom_range(0, 7) << 2);
                else
                    a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
                do_txn(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, rd_v, er_v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave at the far end of the CPU load/store path.
- Accepts one word-aligned request per transaction from the MEM stage.
  - A write carries a 4-bit byte-lane select and lane-replicated write data.
  - A read always returns the full 32-bit word; the MEM stage extracts bytes and halfwords itself.
- Inserts a programmable number of wait states and holds the pipeline via stall_o until it answers with a one-cycle ack_o.

Parameters:
- ADDR_WIDTH, 10: word-index bits. Depth = 2^ADDR_WIDTH words (4 KiB at default).
- LATENCY, 2: wait cycles between accept and response. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_i  in  1  request valid, held by the MEM stage until ack_o.
- wr_i  in  1  1 = write, 0 = read.
- sel_i  in  4  byte-lane write enables. Bit n enables byte n (bits [8n+7:8n]). Ignored on reads.
- addr_i  in  32  physical byte address. Bits [1:0] are ignored.
- wdata_i  in  32  write data, already lane-replicated.
- stall_o  out  1  pipeline hold request (combinational).
- ack_o  out  1  one-cycle response strobe (registered).
- rdata_o  out  32  read word (registered). Valid when ack_o=1; held until the next response.
- err_o  out  1  out-of-range flag. Valid with ack_o.

Behaviour:
- Reset: asynchronous, resetn=0.
  - State goes to IDLE; ack_o=0, err_o=0, rdata_o=0, wait counter=0.
  - Memory contents are not reset.
- Word index = addr_i[ADDR_WIDTH+1:2]. The address is in range iff addr_i[31:ADDR_WIDTH+2] == 0.
- States: IDLE, WAIT, RESP.
  - IDLE: on a clock edge with req_i=1, latch wr_i, sel_i, addr_i and wdata_i.
    - If LATENCY=0, go to RESP.
    - Otherwise load counter=LATENCY-1 and go to WAIT.
  - WAIT: at each edge, if counter=0 go to RESP; otherwise decrement. Input changes are ignored (latched values are used).
  - RESP: lasts exactly one cycle, ack_o=1, then returns to IDLE unconditionally.
    - req_i in this cycle is ignored. This forces one IDLE bubble between back-to-back transactions.
- Timing: with accept edge at t0, ack_o is high during the cycle following edge t0+LATENCY. Request-cycle to ack-cycle is therefore LATENCY+1 cycles.
- stall_o = (IDLE && req_i) || WAIT. It is 0 in RESP and in IDLE without a request.
- Commit edge (the edge that enters RESP):
  - In-range write: mem[idx] byte n <= wdata byte n for each sel bit n set. Other bytes are unchanged. rdata_o is unchanged.
  - In-range read: rdata_o <= mem[idx] (word value before any same-edge write; there is none, since the port is single).
  - Out-of-range: no memory update, rdata_o <= 0, err_o=1 with ack_o.
  - err_o clears to 0 on the next accepted transaction's response, and to 0 when ack_o drops.
- Write with sel=0000 still completes and acks, and changes no memory.
- Reset mid-transaction (WAIT): the transaction is dropped, no write occurs, and no ack is issued after reset releases. A request still asserted after reset is accepted as new.
- Read-after-write to the same word in consecutive transactions returns the merged data.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - BYTE_LANES=4 and the LATENCY legal maximum (15), with the counter width (4 bits) derived from it.
- One sub-module, dmem_array:
  - single-port 2^ADDR_WIDTH x 32 synchronous RAM;
  - per-byte write enable and registered read;
  - driven by the FSM at the commit edge.

Test Plan:
- Reset: hold resetn=0 with req_i=1 → ack_o=0, stall_o=0 until release. After release the request is accepted, and with LATENCY=2 ack_o rises 3 cycles after the first IDLE sample.
- Full word: write 0xDEADBEEF to 0x00000010 with sel=1111, then read 0x00000010 → rdata_o=0xDEADBEEF, err_o=0. stall_o is high exactly 3 cycles per transaction at LATENCY=2.
- Byte merge: after the word above, write wdata=0x55555555 with sel=0010, then write wdata=0xAAAAAAAA with sel=1000, then read → 0xAAAD55EF. A write with sel=0000 leaves 0xAAAD55EF unchanged.
- Out-of-range (ADDR_WIDTH=10): write to 0x00001000 → ack_o=1, err_o=1, memory unchanged. A read of 0x00001000 gives rdata_o=0 and err_o=1. A following in-range read gives err_o=0.
- LATENCY=0: req_i held high across 4 reads → ack_o high in alternate cycles (1 response every 2 cycles). stall_o equals req_i in IDLE cycles and is low in RESP cycles.
- Reset in WAIT (LATENCY=5): drop resetn for 1 cycle, 2 cycles after accepting a write of 0x12345678 to 0x20 → no ack for that transaction, and a later read of 0x20 returns the old contents.
